// File: rtl/pci_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pci_arbiter
// Description : Round-robin PCI bus arbiter. It parks the bus on a chosen
//               master, inserts one dead cycle on every ownership change and
//               reclaims idle grants after a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pci_arbiter #(
    parameter int NREQ         = 4,
    parameter int PARK_ID      = 0,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_n,
    input  logic            frame_n,
    input  logic            irdy_n,
    output logic [NREQ-1:0] gnt_n,
    output logic [2:0]      owner,
    output logic            parked,
    output logic            timeout
);

    localparam logic [1:0]      c_ST_DEAD  = 2'd0;
    localparam logic [1:0]      c_ST_GRANT = 2'd1;
    localparam logic [1:0]      c_ST_BUSY  = 2'd2;
    localparam logic [2:0]      c_LAST_RST = 3'(NREQ - 1);
    localparam logic [2:0]      c_PARK     = 3'(PARK_ID);
    localparam logic [4:0]      c_TIMEOUT  = 5'(IDLE_TIMEOUT);
    localparam logic [NREQ-1:0] c_ALL_HIGH = {NREQ{1'b1}};

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_gnt_n;
    logic [2:0]      r_owner;
    logic [2:0]      r_last;
    logic            r_parked;
    logic            r_timeout;
    logic [4:0]      r_timer;

    logic            w_bus_idle;
    logic            w_any_req;
    logic            w_owner_req;
    logic            w_other_req;
    logic            w_found;
    logic [2:0]      w_winner;
    logic [NREQ-1:0] w_owner_sel;
    logic [NREQ-1:0] w_win_gnt_n;
    logic [4:0]      w_timer_inc;

    assign w_bus_idle  = frame_n & irdy_n;
    assign w_any_req   = ~&req_n;
    assign w_owner_req = |(~req_n & w_owner_sel);
    assign w_other_req = |(~req_n & ~w_owner_sel);
    assign w_timer_inc = r_timer + 5'd1;

    // Decode the current owner and the pending winner into per-master vectors
    always_comb begin
        w_owner_sel = '0;
        w_win_gnt_n = c_ALL_HIGH;
        for (int j = 0; j < NREQ; j++) begin
            w_owner_sel[j] = (r_owner == 3'(j));
            w_win_gnt_n[j] = (w_winner != 3'(j));
        end
    end

    // Round-robin search starting just after the last grantee; park if idle
    always_comb begin
        w_winner = c_PARK;
        w_found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && (j == (int'(r_last) + i) % NREQ) && !req_n[j]) begin
                    w_winner = 3'(j);
                    w_found  = 1'b1;
                end
            end
        end
    end

    // Arbitration state machine; all outputs are registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_DEAD;
            r_gnt_n   <= c_ALL_HIGH;
            r_owner   <= c_LAST_RST;
            r_last    <= c_LAST_RST;
            r_parked  <= 1'b0;
            r_timeout <= 1'b0;
            r_timer   <= 5'd0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_ST_DEAD: begin
                    r_gnt_n  <= w_win_gnt_n;
                    r_owner  <= w_winner;
                    r_last   <= w_winner;
                    r_parked <= ~w_found;
                    r_timer  <= 5'd0;
                    r_state  <= c_ST_GRANT;
                end
                c_ST_GRANT: begin
                    if (!frame_n) begin
                        // Grantee started a transaction; it now owns the bus
                        r_state  <= c_ST_BUSY;
                        r_parked <= 1'b0;
                    end else if (!r_parked && !w_owner_req) begin
                        r_state <= c_ST_DEAD;
                        r_gnt_n <= c_ALL_HIGH;
                    end else if (r_parked && w_any_req) begin
                        r_state <= c_ST_DEAD;
                        r_gnt_n <= c_ALL_HIGH;
                    end else if (!r_parked && w_bus_idle && (w_timer_inc == c_TIMEOUT)) begin
                        r_state   <= c_ST_DEAD;
                        r_gnt_n   <= c_ALL_HIGH;
                        r_timeout <= 1'b1;
                    end else if (!r_parked && w_bus_idle) begin
                        r_timer <= w_timer_inc;
                    end
                end
                c_ST_BUSY: begin
                    if (w_other_req) begin
                        // Preempt; the owner's latency timer ends its burst
                        r_state <= c_ST_DEAD;
                        r_gnt_n <= c_ALL_HIGH;
                    end else if (w_bus_idle && w_owner_req) begin
                        r_state <= c_ST_GRANT;
                        r_timer <= 5'd0;
                    end else if (w_bus_idle) begin
                        r_state <= c_ST_DEAD;
                        r_gnt_n <= c_ALL_HIGH;
                    end
                end
                default: begin
                    r_state <= c_ST_DEAD;
                    r_gnt_n <= c_ALL_HIGH;
                end
            endcase
        end
    end

    assign gnt_n   = r_gnt_n;
    assign owner   = r_owner;
    assign parked  = r_parked;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pci_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pci_arbiter
// Description : Self-checking bench for pci_arbiter. Each step drives inputs,
//               queues the hand-derived expected outputs for the next edge
//               and compares them once the DUT has updated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [2:0] owner;
    logic       parked;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    gnt;
        int    own;
        int    prk;   // -1 = not checked
        int    tmo;
    } exp_t;

    exp_t sb[$];

    pci_arbiter #(
        .NREQ         (4),
        .PARK_ID      (0),
        .IDLE_TIMEOUT (16)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req_n   (req_n),
        .frame_n (frame_n),
        .irdy_n  (irdy_n),
        .gnt_n   (gnt_n),
        .owner   (owner),
        .parked  (parked),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int gnt_of(input int m);
        return 15 & ~(1 << m);
    endfunction

    // Drive one cycle of stimulus, queue the expectation, compare after the edge
    task automatic step(input string tag, input logic rst_v, input logic [3:0] req_v,
                        input logic frame_v, input logic irdy_v,
                        input int e_gnt, input int e_own, input int e_prk, input int e_tmo);
        exp_t e;
        exp_t g;
        reset   = rst_v;
        req_n   = req_v;
        frame_n = frame_v;
        irdy_n  = irdy_v;
        e.tag = tag; e.gnt = e_gnt; e.own = e_own; e.prk = e_prk; e.tmo = e_tmo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_eq({g.tag, ".gnt_n"},   int'(gnt_n),   g.gnt);
        check_eq({g.tag, ".owner"},   int'(owner),   g.own);
        if (g.prk >= 0)
            check_eq({g.tag, ".parked"}, int'(parked), g.prk);
        check_eq({g.tag, ".timeout"}, int'(timeout), g.tmo);
        check_eq({g.tag, ".onecold"}, int'($countones(~gnt_n) <= 1), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk     = 1'b0;
        reset   = 1'b1;
        req_n   = 4'hF;
        frame_n = 1'b1;
        irdy_n  = 1'b1;

        // Reset and park
        step("rst0", 1, 4'hF, 1, 1, 15, 3, 0, 0);
        step("rst1", 1, 4'hF, 1, 1, 15, 3, 0, 0);
        step("park", 0, 4'hF, 1, 1, 4'hE, 0, 1, 0);
        for (int n = 0; n < 20; n++)
            step("park_hold", 0, 4'hF, 1, 1, 4'hE, 0, 1, 0);

        // Single request from park
        step("pk_req",  0, 4'hB, 1, 1, 15,   0, -1, 0);
        step("pk_gnt",  0, 4'hB, 1, 1, 4'hB, 2, 0, 0);
        for (int n = 0; n < 3; n++)
            step("pk_frame", 0, 4'hB, 0, 1, 4'hB, 2, 0, 0);
        step("pk_done", 0, 4'hF, 1, 1, 15,   2, -1, 0);
        step("pk_park", 0, 4'hF, 1, 1, 4'hE, 0, 1, 0);

        // Round-robin with every master requesting
        step("rr_rst",   1, 4'hF, 1, 1, 15,   3, 0, 0);
        step("rr_first", 0, 4'h0, 1, 1, 4'hE, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step("rr_busy", 0, 4'h0, 0, 1, gnt_of(k), k, 0, 0);
            step("rr_dead", 0, 4'h0, 0, 1, 15, k, -1, 0);
            step("rr_next", 0, 4'h0, 1, 1, gnt_of((k + 1) % 4), (k + 1) % 4, 0, 0);
        end

        // Idle timeout on master 1, master 2 waiting
        step("to_rel", 0, 4'hD, 1, 1, 15, 0, -1, 0);
        step("to_gnt", 0, 4'h9, 1, 1, gnt_of(1), 1, 0, 0);
        for (int n = 1; n < 16; n++)
            step("to_wait", 0, 4'h9, 1, 1, gnt_of(1), 1, 0, 0);
        step("to_fire", 0, 4'h9, 1, 1, 15, 1, -1, 1);
        step("to_next", 0, 4'h9, 1, 1, gnt_of(2), 2, 0, 0);

        // Preemption of a busy master 0 by master 3
        step("pe_rel",   0, 4'hE, 1, 1, 15,   2, -1, 0);
        step("pe_gnt",   0, 4'hE, 1, 1, 4'hE, 0, 0, 0);
        step("pe_busy",  0, 4'hE, 0, 1, 4'hE, 0, 0, 0);
        step("pe_busy",  0, 4'hE, 0, 1, 4'hE, 0, 0, 0);
        step("pe_req3",  0, 4'h6, 0, 1, 15,   0, -1, 0);
        step("pe_gnt3",  0, 4'h6, 0, 1, 4'h7, 3, 0, 0);
        step("pe_busy3", 0, 4'h7, 0, 1, 4'h7, 3, 0, 0);
        step("pe_b2b",   0, 4'h7, 1, 1, 4'h7, 3, 0, 0);

        // Reset pulse while master 2 is busy
        step("rb_rel",     0, 4'hB, 1, 1, 15,   3, -1, 0);
        step("rb_gnt",     0, 4'hB, 1, 1, 4'hB, 2, 0, 0);
        step("rb_busy",    0, 4'hB, 0, 1, 4'hB, 2, 0, 0);
        step("rb_rst",     1, 4'hB, 0, 1, 15,   3, 0, 0);
        step("rb_restart", 0, 4'h0, 1, 1, 4'hE, 0, 0, 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
